pkt_disassembler: RTL and testbench

//  Receive side of the SpiNNaker multicast packet path. Accepts 72-bit packets
//  ({payload[31:0], key[31:0], header[7:0]}) and checks parity, type and a
//  key/mask filter. Forwards the key, payload and payload-present flag of good

---
 rtl/pkt_disassembler.sv | 124 ++++++++++++
 tb/tb_pkt_disassembler.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_disassembler.sv
// Multicast receive checker: drops bad-parity/non-MC/filtered packets, forwards the rest as events.
// Latency 1 cycle; 1-entry park absorbs one packet under evt backpressure, then pkt_rdy_out drops.
module pkt_disassembler #(
  parameter int PACKET_BITS = 72,
  parameter int CNT_BITS    = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [31:0]            flt_key_in,
  input  logic [31:0]            flt_msk_in,
  input  logic [PACKET_BITS-1:0] pkt_data_in,
  input  logic                   pkt_vld_in,
  output logic                   pkt_rdy_out,
  output logic [31:0]            evt_key_out,
  output logic [31:0]            evt_pld_out,
  output logic                   evt_pp_out,
  output logic                   evt_vld_out,
  input  logic                   evt_rdy_in,
  output logic [CNT_BITS-1:0]    par_err_cnt,
  output logic [CNT_BITS-1:0]    typ_drp_cnt,
  output logic [CNT_BITS-1:0]    flt_drp_cnt,
  input  logic                   cnt_clr_in
);

  logic        accept;
  logic        par_ok;
  logic        typ_ok;
  logic        flt_ok;
  logic        good;
  logic        busy;
  logic        park_nxt;
  logic [31:0] in_key;
  logic [31:0] in_pld;
  logic        in_pp;

  logic        park_vld;
  logic [31:0] park_key;
  logic [31:0] park_pld;
  logic        park_pp;

  always_comb begin
    accept   = pkt_vld_in && pkt_rdy_out;
    par_ok   = ^pkt_data_in;
    typ_ok   = (pkt_data_in[7:6] == 2'b00);
    in_key   = pkt_data_in[39:8];
    in_pp    = pkt_data_in[1];
    in_pld   = in_pp ? pkt_data_in[71:40] : 32'h0;
    flt_ok   = ((in_key & flt_msk_in) == flt_key_in);
    good     = accept && par_ok && typ_ok && flt_ok;
    busy     = evt_vld_out && !evt_rdy_in;
    // Park can only be occupied while the output is stalled; a free output always drains it.
    park_nxt = busy && (park_vld || good);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pkt_rdy_out <= 1'b0;
      evt_vld_out <= 1'b0;
      evt_key_out <= 32'h0;
      evt_pld_out <= 32'h0;
      evt_pp_out  <= 1'b0;
      park_vld    <= 1'b0;
      park_key    <= 32'h0;
      park_pld    <= 32'h0;
      park_pp     <= 1'b0;
    end else begin
      pkt_rdy_out <= !park_nxt;
      park_vld    <= park_nxt;
      if (!busy) begin
        if (park_vld) begin
          evt_vld_out <= 1'b1;
          evt_key_out <= park_key;
          evt_pld_out <= park_pld;
          evt_pp_out  <= park_pp;
        end else if (good) begin
          evt_vld_out <= 1'b1;
          evt_key_out <= in_key;
          evt_pld_out <= in_pld;
          evt_pp_out  <= in_pp;
        end else begin
          evt_vld_out <= 1'b0;
        end
      end else if (good) begin
        park_key <= in_key;
        park_pld <= in_pld;
        park_pp  <= in_pp;
      end
    end
  end

  logic par_drop;
  logic typ_drop;
  logic flt_drop;

  always_comb begin
    par_drop = accept && !par_ok;
    typ_drop = accept && par_ok && !typ_ok;
    flt_drop = accept && par_ok && typ_ok && !flt_ok;
  end

  function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] c, input logic inc);
    if (inc && (c != {CNT_BITS{1'b1}}))
      return c + {{(CNT_BITS-1){1'b0}}, 1'b1};
    return c;
  endfunction

  // Clear takes precedence over a same-cycle increment.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      par_err_cnt <= '0;
      typ_drp_cnt <= '0;
      flt_drp_cnt <= '0;
    end else if (cnt_clr_in) begin
      par_err_cnt <= '0;
      typ_drp_cnt <= '0;
      flt_drp_cnt <= '0;
    end else begin
      par_err_cnt <= sat_inc(par_err_cnt, par_drop);
      typ_drp_cnt <= sat_inc(typ_drp_cnt, typ_drop);
      flt_drp_cnt <= sat_inc(flt_drp_cnt, flt_drop);
    end
  end

endmodule

// File: tb/tb_pkt_disassembler.sv
// Randomized scoreboard bench for pkt_disassembler with a classify-and-queue reference model.
module tb_pkt_disassembler;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] flt_key_in;
  logic [31:0] flt_msk_in;
  logic [71:0] pkt_data_in;
  logic        pkt_vld_in;
  logic        pkt_rdy_out;
  logic [31:0] evt_key_out;
  logic [31:0] evt_pld_out;
  logic        evt_pp_out;
  logic        evt_vld_out;
  logic        evt_rdy_in;
  logic [15:0] par_err_cnt;
  logic [15:0] typ_drp_cnt;
  logic [15:0] flt_drp_cnt;
  logic        cnt_clr_in;

  pkt_disassembler #(.PACKET_BITS(72), .CNT_BITS(16)) dut (
    .clk(clk), .reset(reset),
    .flt_key_in(flt_key_in), .flt_msk_in(flt_msk_in),
    .pkt_data_in(pkt_data_in), .pkt_vld_in(pkt_vld_in), .pkt_rdy_out(pkt_rdy_out),
    .evt_key_out(evt_key_out), .evt_pld_out(evt_pld_out), .evt_pp_out(evt_pp_out),
    .evt_vld_out(evt_vld_out), .evt_rdy_in(evt_rdy_in),
    .par_err_cnt(par_err_cnt), .typ_drp_cnt(typ_drp_cnt), .flt_drp_cnt(flt_drp_cnt),
    .cnt_clr_in(cnt_clr_in)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] key;
    logic [31:0] pld;
    logic        pp;
  } evt_t;

  evt_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] m_par = 16'h0;
  logic [15:0] m_typ = 16'h0;
  logic [15:0] m_flt = 16'h0;

  logic [71:0] d_pkt = 72'h0;
  logic        d_vld = 1'b0;
  logic        d_clr = 1'b0;
  logic        d_erdy = 1'b1;
  logic [31:0] d_fk = 32'h0;
  logic [31:0] d_fm = 32'h0;
  bit          rnd_rdy = 0;
  bit          accepted;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // 0 good, 1 parity, 2 type, 3 filter
  function automatic int classify(input logic [71:0] p, input logic [31:0] fk, input logic [31:0] fm);
    if (($countones(p) % 2) == 0) return 1;
    if (p[7:6] != 2'b00) return 2;
    if ((p[39:8] & fm) != fk) return 3;
    return 0;
  endfunction

  function automatic logic [15:0] sat(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  // Builds a packet with odd parity by adjusting the ignored header bit 2.
  function automatic logic [71:0] mk(input logic [31:0] pld, input logic [31:0] key, input logic [7:0] hdr);
    logic [71:0] p;
    p = {pld, key, hdr};
    p[2] = 1'b0;
    if (($countones(p) % 2) == 0) p[2] = 1'b1;
    return p;
  endfunction

  task automatic model_cycle();
    int   c;
    evt_t e;
    accepted = pkt_vld_in && pkt_rdy_out && reset;
    c = accepted ? classify(pkt_data_in, flt_key_in, flt_msk_in) : -1;
    if (c == 0) begin
      e.key = pkt_data_in[39:8];
      e.pp  = pkt_data_in[1];
      e.pld = pkt_data_in[1] ? pkt_data_in[71:40] : 32'h0;
      exp_q.push_back(e);
    end
    if (cnt_clr_in) begin
      m_par = 16'h0; m_typ = 16'h0; m_flt = 16'h0;
    end else begin
      if (c == 1) m_par = sat(m_par);
      if (c == 2) m_typ = sat(m_typ);
      if (c == 3) m_flt = sat(m_flt);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (rnd_rdy) d_erdy = ($urandom_range(0, 3) != 0);
    pkt_data_in = d_pkt;
    pkt_vld_in  = d_vld;
    cnt_clr_in  = d_clr;
    evt_rdy_in  = d_erdy;
    flt_key_in  = d_fk;
    flt_msk_in  = d_fm;
    @(negedge clk);
    model_cycle();
  endtask

  task automatic send(input logic [71:0] p);
    d_pkt = p;
    d_vld = 1'b1;
    accepted = 0;
    for (int n = 0; n < 50 && !accepted; n++) step();
    chk("accept", accepted, 1'b1);
    d_vld = 1'b0;
  endtask

  task automatic idle(input int n);
    d_vld = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic chk_cnt();
    chk("par_err_cnt", par_err_cnt, m_par);
    chk("typ_drp_cnt", typ_drp_cnt, m_typ);
    chk("flt_drp_cnt", flt_drp_cnt, m_flt);
  endtask

  task automatic drain();
    d_erdy = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1);
    idle(2);
    chk("drain", exp_q.size(), 0);
  endtask

  // Monitor: compares every taken event and checks outputs stay put while stalled.
  bit          hold = 0;
  logic [64:0] prev;
  always @(negedge clk) begin
    evt_t e;
    if (!reset) begin
      hold = 0;
    end else begin
      if (hold) begin
        chk("hold_vld", evt_vld_out, 1'b1);
        chk("hold_data", {evt_key_out, evt_pld_out, evt_pp_out}, prev);
      end
      if (evt_vld_out && evt_rdy_in) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event: got key %h, none expected", evt_key_out);
        end else begin
          e = exp_q.pop_front();
          chk("evt", {evt_key_out, evt_pld_out, evt_pp_out}, {e.key, e.pld, e.pp});
        end
      end
      hold = evt_vld_out && !evt_rdy_in;
      prev = {evt_key_out, evt_pld_out, evt_pp_out};
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    pkt_data_in = 72'h0; pkt_vld_in = 1'b0; cnt_clr_in = 1'b0;
    evt_rdy_in = 1'b1; flt_key_in = 32'h0; flt_msk_in = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_rdy", pkt_rdy_out, 1'b0);
    chk("rst_vld", evt_vld_out, 1'b0);
    chk("rst_evt", {evt_key_out, evt_pld_out, evt_pp_out}, 65'h0);
    chk_cnt();
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    chk("rdy_before_edge", pkt_rdy_out, 1'b0);
    step();
    chk("rdy_after_edge", pkt_rdy_out, 1'b1);

    // Good MC, no payload flag: payload bits must be masked.
    send({32'hDEAD_BEEF, 32'h1234_5678, 8'h00});
    idle(1);
    chk("t1_vld", evt_vld_out, 1'b1);
    chk("t1_key", evt_key_out, 32'h1234_5678);
    chk("t1_pld", evt_pld_out, 32'h0);
    idle(1);
    chk("t1_vld_fall", evt_vld_out, 1'b0);
    chk_cnt();

    send({32'h0000_0001, 32'h1234_5678, 8'h02});
    idle(1);
    chk("t2_pld_pp", {evt_pld_out, evt_pp_out}, {32'h1, 1'b1});
    idle(1);

    send({32'h0, 32'h1234_5678, 8'h01});
    send({32'h0, 32'h1234_5678, 8'h81});
    d_fm = 32'hFFFF_0000; d_fk = 32'hABCD_0000;
    send({32'h0, 32'h1234_5678, 8'h00});
    idle(2);
    chk("t3_vld", evt_vld_out, 1'b0);
    chk("t3_counts", {par_err_cnt, typ_drp_cnt, flt_drp_cnt}, {16'd1, 16'd1, 16'd1});
    chk_cnt();
    d_fm = 32'h0; d_fk = 32'h0;

    // Backpressure with park.
    d_erdy = 1'b0;
    send(mk(32'h0, 32'd1, 8'h00));
    send(mk(32'h0, 32'd2, 8'h00));
    d_pkt = mk(32'h0, 32'd3, 8'h00); d_vld = 1'b1;
    step();
    chk("t4_rdy_low", pkt_rdy_out, 1'b0);
    step(); step();
    chk("t4_stalled", accepted, 1'b0);
    chk("t4_head", {evt_vld_out, evt_key_out}, {1'b1, 32'd1});
    d_erdy = 1'b1;
    send(mk(32'h0, 32'd3, 8'h00));
    drain();

    // Randomized traffic.
    rnd_rdy = 1;
    for (int i = 0; i < 1500; i++) begin
      logic [31:0] key;
      logic [7:0]  hdr;
      logic [71:0] p;
      if ($urandom_range(0, 49) == 0) begin
        d_fm = $urandom & $urandom;
        d_fk = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & d_fm);
      end
      key = $urandom;
      if ($urandom_range(0, 1) == 0) key = (key & ~d_fm) | d_fk;
      hdr = $urandom;
      if ($urandom_range(0, 5) != 0) hdr[7:6] = 2'b00;
      p = mk($urandom, key, hdr);
      if ($urandom_range(0, 7) == 0) p[3] = ~p[3];
      d_clr = ($urandom_range(0, 99) == 0);
      send(p);
      d_clr = 1'b0;
      if ($urandom_range(0, 9) == 0) idle($urandom_range(1, 3));
    end
    rnd_rdy = 0;
    d_fm = 32'h0; d_fk = 32'h0;
    drain();
    chk_cnt();

    // Saturation and clear precedence.
    d_clr = 1'b1; idle(1); d_clr = 1'b0;
    for (int i = 0; i < 65536 + 3; i++) send({32'h0, 32'h1234_5678, 8'h01});
    idle(1);
    chk("t5_sat", par_err_cnt, 16'hFFFF);
    chk_cnt();
    d_clr = 1'b1;
    send({32'h0, 32'h1234_5678, 8'h01});
    d_clr = 1'b0;
    idle(1);
    chk("t5_clr", par_err_cnt, 16'h0);
    chk_cnt();

    // Reset while stalled with a parked event.
    d_erdy = 1'b0;
    send(mk(32'h0, 32'd4, 8'h00));
    send(mk(32'h0, 32'd5, 8'h00));
    d_pkt = mk(32'h0, 32'd6, 8'h00); d_vld = 1'b1;
    step(); step();
    d_vld = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0; pkt_vld_in = 1'b0;
    exp_q.delete();
    m_par = 16'h0; m_typ = 16'h0; m_flt = 16'h0;
    @(negedge clk);
    chk("t6_rst_out", {evt_vld_out, evt_key_out, evt_pld_out, evt_pp_out, pkt_rdy_out}, 67'h0);
    chk_cnt();
    @(posedge clk); #1 reset = 1'b1;
    d_erdy = 1'b1;
    idle(3);
    chk("t6_no_old", evt_vld_out, 1'b0);
    send(mk(32'h0, 32'd7, 8'h00));
    idle(1);
    chk("t6_new", {evt_vld_out, evt_key_out}, {1'b1, 32'd7});
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
